// File: rtl/regfile_writeback_if.sv
// Result handshake bundle between the ALU / load unit and the
// register-file write-back controller.
//
// Signals (producer -> controller unless noted):
//   AluValid/AluDest/AluData    ALU result offer
//   AluReady  (controller->)    ALU result accepted when AluValid & AluReady
//   LoadValid/LoadDest/LoadData load result offer
//   LoadReady (controller->)    load result accepted when LoadValid & LoadReady
interface regfile_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              AluValid;
    logic              AluReady;
    logic [ADDR_W-1:0] AluDest;
    logic [DATA_W-1:0] AluData;
    logic              LoadValid;
    logic              LoadReady;
    logic [ADDR_W-1:0] LoadDest;
    logic [DATA_W-1:0] LoadData;

    modport master (
        output AluValid,
        output AluDest,
        output AluData,
        output LoadValid,
        output LoadDest,
        output LoadData,
        input  AluReady,
        input  LoadReady
    );

    modport slave (
        input  AluValid,
        input  AluDest,
        input  AluData,
        input  LoadValid,
        input  LoadDest,
        input  LoadData,
        output AluReady,
        output LoadReady
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write-side controller for the register file: buffers ALU and load
// results in an in-order FIFO, drains one write per cycle, and keeps a
// per-register busy scoreboard for the issue logic.
//
// Ports:
//   clk, reset   single rising-edge clock, synchronous active-high reset
//   res          result handshakes (slave side of regfile_writeback_if)
//   IssueValid   an issued instruction will write IssueDest
//   IssueDest    destination of the issued instruction
//   Destination  register-file write index (registered)
//   Din          register-file write data (registered)
//   WriteEn      register-file write strobe, one cycle per write
//   Busy         scoreboard, bit r = write to r outstanding
//   Pending      entries currently held in the FIFO
module regfile_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int NREG      = 1 << ADDR_W,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    regfile_writeback_if.slave res,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueDest,
    output logic [ADDR_W-1:0] Destination,
    output logic [DATA_W-1:0] Din,
    output logic              WriteEn,
    output logic [NREG-1:0]   Busy,
    output logic [CNT_W-1:0]  Pending
);

    logic [ADDR_W-1:0] dest_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] free;

    logic load_rdy;
    logic alu_rdy;
    logic load_acc;
    logic alu_acc;
    logic pop;

    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Free space is taken from the registered count only; a pop in the
    // same cycle never lends credit to an incoming result.
    assign free = CNT_W'(FIFO_DEPTH) - Pending;

    // Load wins the last free slot, so the ALU side looks at LoadValid.
    always_comb begin
        load_rdy = 1'b0;
        alu_rdy  = 1'b0;
        if (!reset) begin
            load_rdy = (free >= CNT_W'(1));
            alu_rdy  = (free >= CNT_W'(2)) ||
                       ((free == CNT_W'(1)) && !res.LoadValid);
        end
    end

    assign res.LoadReady = load_rdy;
    assign res.AluReady  = alu_rdy;

    assign load_acc = res.LoadValid && load_rdy;
    assign alu_acc  = res.AluValid && alu_rdy;
    assign pop      = (Pending != '0);

    // When both arrive together the load goes first in FIFO order.
    assign alu_slot = wr_ptr + PTR_W'(load_acc);

    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (IssueValid) begin
            set_mask[IssueDest] = 1'b1;
        end
        if (pop) begin
            clr_mask[head_dest] = 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below Pending.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            dest_mem[wr_ptr] <= res.LoadDest;
            data_mem[wr_ptr] <= res.LoadData;
        end
        if (alu_acc) begin
            dest_mem[alu_slot] <= res.AluDest;
            data_mem[alu_slot] <= res.AluData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Pending <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(load_acc) + PTR_W'(alu_acc);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            Pending <= Pending + CNT_W'(load_acc) + CNT_W'(alu_acc)
                       - CNT_W'(pop);
        end
    end

    // Destination/Din keep their last value while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            WriteEn     <= 1'b0;
            Destination <= '0;
            Din         <= '0;
        end else begin
            WriteEn <= pop;
            if (pop) begin
                Destination <= head_dest;
                Din         <= head_data;
            end
        end
    end

    // A new issue to r beats the retiring write to r at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            Busy <= '0;
        end else begin
            Busy <= (Busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference
// model compared every cycle plus literal spot checks.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IssueValid = 1'b0;
    logic [3:0]  IssueDest = '0;
    logic [3:0]  Destination;
    logic [31:0] Din;
    logic        WriteEn;
    logic [15:0] Busy;
    logic [2:0]  Pending;

    int tests = 0;
    int fails = 0;

    regfile_writeback_if #(.DATA_W(32), .ADDR_W(4)) rif();

    regfile_writeback #(
        .DATA_W(32),
        .ADDR_W(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .res(rif),
        .IssueValid(IssueValid),
        .IssueDest(IssueDest),
        .Destination(Destination),
        .Din(Din),
        .WriteEn(WriteEn),
        .Busy(Busy),
        .Pending(Pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    logic        m_we = 1'b0;
    logic [3:0]  m_dest = '0;
    logic [31:0] m_din = '0;
    logic [15:0] m_busy = '0;
    bit          armed = 1'b0;

    // Reference model: a plain queue of accepted results.
    always @(posedge clk) begin
        int   n;
        bit   lacc;
        bit   aacc;
        ent_t e;
        if (reset) begin
            q.delete();
            m_we = 1'b0;
            m_dest = '0;
            m_din = '0;
            m_busy = '0;
            armed = 1'b1;
        end else begin
            n = 4 - q.size();
            lacc = rif.LoadValid && n >= 1;
            aacc = rif.AluValid && (n >= 2 || (n == 1 && !rif.LoadValid));
            if (q.size() != 0) begin
                e = q.pop_front();
                m_we = 1'b1;
                m_dest = e.d;
                m_din = e.v;
                m_busy[e.d] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (IssueValid) m_busy[IssueDest] = 1'b1;
            if (lacc) q.push_back('{rif.LoadDest, rif.LoadData});
            if (aacc) q.push_back('{rif.AluDest, rif.AluData});
        end
    end

    always @(negedge clk) begin
        int  n;
        bit  elr;
        bit  ear;
        if (armed) begin
            n = 4 - q.size();
            elr = !reset && n >= 1;
            ear = !reset && (n >= 2 || (n == 1 && !rif.LoadValid));
            chk("m_WriteEn", 32'(WriteEn), 32'(m_we));
            chk("m_Destination", 32'(Destination), 32'(m_dest));
            chk("m_Din", Din, m_din);
            chk("m_Busy", 32'(Busy), 32'(m_busy));
            chk("m_Pending", 32'(Pending), 32'(q.size()));
            chk("m_LoadReady", 32'(rif.LoadReady), 32'(elr));
            chk("m_AluReady", 32'(rif.AluReady), 32'(ear));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.AluValid = 1'b0;
        rif.LoadValid = 1'b0;
        IssueValid = 1'b0;
    endtask

    task automatic alu(input logic [3:0] d, input logic [31:0] v);
        rif.AluValid = 1'b1;
        rif.AluDest = d;
        rif.AluData = v;
    endtask

    task automatic load(input logic [3:0] d, input logic [31:0] v);
        rif.LoadValid = 1'b1;
        rif.LoadDest = d;
        rif.LoadData = v;
    endtask

    initial begin
        rif.AluValid = 1'b0;
        rif.AluDest = '0;
        rif.AluData = '0;
        rif.LoadValid = 1'b0;
        rif.LoadDest = '0;
        rif.LoadData = '0;

        // reset state
        cyc();
        chk("rst_LoadReady", 32'(rif.LoadReady), 32'd0);
        chk("rst_AluReady", 32'(rif.AluReady), 32'd0);
        cyc();
        chk("rst_WriteEn", 32'(WriteEn), 32'd0);
        chk("rst_Pending", 32'(Pending), 32'd0);
        chk("rst_Busy", 32'(Busy), 32'd0);
        chk("rst_Din", Din, 32'd0);
        reset = 1'b0;
        cyc();

        // 1: single ALU write, one-cycle latency after acceptance
        alu(4'd3, 32'hDEADBEEF);
        #1;
        chk("t1_AluReady", 32'(rif.AluReady), 32'd1);
        cyc();
        idle();
        chk("t1_Pending1", 32'(Pending), 32'd1);
        chk("t1_noWE", 32'(WriteEn), 32'd0);
        cyc();
        chk("t1_WE", 32'(WriteEn), 32'd1);
        chk("t1_Dest", 32'(Destination), 32'd3);
        chk("t1_Din", Din, 32'hDEADBEEF);
        chk("t1_Pending0", 32'(Pending), 32'd0);
        cyc();
        chk("t1_WEoff", 32'(WriteEn), 32'd0);
        chk("t1_DinHold", Din, 32'hDEADBEEF);

        // 2: load and ALU together, load written first
        load(4'd5, 32'h11);
        alu(4'd6, 32'h22);
        #1;
        chk("t2_LoadReady", 32'(rif.LoadReady), 32'd1);
        chk("t2_AluReady", 32'(rif.AluReady), 32'd1);
        cyc();
        idle();
        chk("t2_Pending2", 32'(Pending), 32'd2);
        cyc();
        chk("t2_Dest5", 32'(Destination), 32'd5);
        chk("t2_Din11", Din, 32'h11);
        cyc();
        chk("t2_Dest6", 32'(Destination), 32'd6);
        chk("t2_Din22", Din, 32'h22);
        chk("t2_WE", 32'(WriteEn), 32'd1);
        cyc();
        chk("t2_WEoff", 32'(WriteEn), 32'd0);

        // 3: fill to 3 entries, load takes the last slot
        load(4'd8, 32'h1);
        alu(4'd9, 32'h2);
        cyc();
        load(4'd10, 32'h3);
        alu(4'd11, 32'h4);
        cyc();
        chk("t3_Pending3", 32'(Pending), 32'd3);
        chk("t3_Dest8", 32'(Destination), 32'd8);
        load(4'd12, 32'h5);
        alu(4'd13, 32'h6);
        #1;
        chk("t3_LoadReady", 32'(rif.LoadReady), 32'd1);
        chk("t3_AluBlocked", 32'(rif.AluReady), 32'd0);
        cyc();
        chk("t3_Pending3b", 32'(Pending), 32'd3);
        rif.LoadValid = 1'b0;
        alu(4'd14, 32'h7);
        #1;
        chk("t3_AluReady", 32'(rif.AluReady), 32'd1);
        cyc();
        idle();
        cyc();
        chk("t3_Dest11", 32'(Destination), 32'd11);
        cyc();
        chk("t3_Dest12", 32'(Destination), 32'd12);
        cyc();
        chk("t3_Dest14", 32'(Destination), 32'd14);
        chk("t3_Din7", Din, 32'h7);
        cyc();

        // 4: scoreboard set, clear on pop, set wins over clear
        IssueValid = 1'b1;
        IssueDest = 4'd7;
        cyc();
        idle();
        chk("t4_Busy7set", 32'(Busy), 32'h80);
        alu(4'd7, 32'h77);
        cyc();
        idle();
        chk("t4_Busy7held", 32'(Busy), 32'h80);
        cyc();
        chk("t4_Dest7", 32'(Destination), 32'd7);
        chk("t4_Busy7clr", 32'(Busy), 32'h0);
        alu(4'd7, 32'h78);
        cyc();
        idle();
        IssueValid = 1'b1;
        IssueDest = 4'd7;
        cyc();
        idle();
        chk("t4_WE7", 32'(WriteEn), 32'd1);
        chk("t4_Busy7stay", 32'(Busy), 32'h80);
        cyc();
        chk("t4_Busy7still", 32'(Busy), 32'h80);

        // 5: two writes to the same register keep their order
        alu(4'd2, 32'hA);
        cyc();
        alu(4'd2, 32'hB);
        cyc();
        idle();
        chk("t5_DinA", Din, 32'hA);
        chk("t5_Dest2", 32'(Destination), 32'd2);
        cyc();
        chk("t5_DinB", Din, 32'hB);
        chk("t5_WE", 32'(WriteEn), 32'd1);
        cyc();

        // 6: reset with entries buffered
        IssueValid = 1'b1;
        IssueDest = 4'd4;
        load(4'd1, 32'h100);
        alu(4'd2, 32'h200);
        cyc();
        IssueValid = 1'b0;
        load(4'd3, 32'h300);
        alu(4'd4, 32'h400);
        cyc();
        idle();
        chk("t6_Pending3", 32'(Pending), 32'd3);
        reset = 1'b1;
        rif.AluValid = 1'b1;
        rif.LoadValid = 1'b1;
        #1;
        chk("t6_LoadReady0", 32'(rif.LoadReady), 32'd0);
        chk("t6_AluReady0", 32'(rif.AluReady), 32'd0);
        cyc();
        idle();
        chk("t6_WE0", 32'(WriteEn), 32'd0);
        chk("t6_Pending0", 32'(Pending), 32'd0);
        chk("t6_Busy0", 32'(Busy), 32'd0);
        reset = 1'b0;
        cyc();
        chk("t6_WE0b", 32'(WriteEn), 32'd0);
        chk("t6_Pending0b", 32'(Pending), 32'd0);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
